// File: rtl/fdiv_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM states,
// iteration count, exponent bias and canonical special-value encodings.
package fdiv_pkg;

  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_RND  = 2'd2,
    S_DONE = 2'd3
  } fdiv_state_e;

  // Exponent bias 2^(EXP_W-1)-1.
  function automatic int fdiv_bias(input int exp_w);
    return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
  endfunction

  // Quotient bits produced: hidden bit, FRAC_W fraction bits, guard and one extra.
  function automatic int fdiv_q(input int frac_w);
    return frac_w + 3;
  endfunction

  // Signed infinity: exponent all ones, fraction zero.
  function automatic logic [MAX_W-1:0] fdiv_inf(input int exp_w, input int frac_w,
                                                 input logic sign);
    logic [MAX_W-1:0] v;
    v = ((MAX_W'(1'b1) << exp_w) - MAX_W'(1'b1)) << frac_w;
    v = v | (MAX_W'(sign) << (exp_w + frac_w));
    return v;
  endfunction

  // Canonical quiet NaN: positive, exponent all ones, fraction MSB set.
  function automatic logic [MAX_W-1:0] fdiv_qnan(input int exp_w, input int frac_w);
    logic [MAX_W-1:0] v;
    v = fdiv_inf(exp_w, frac_w, 1'b0);
    v = v | (MAX_W'(1'b1) << (frac_w - 1));
    return v;
  endfunction

  // Signed zero.
  function automatic logic [MAX_W-1:0] fdiv_zero(input int exp_w, input int frac_w,
                                                  input logic sign);
    return MAX_W'(sign) << (exp_w + frac_w);
  endfunction

endpackage

// File: rtl/fdiv_rne.sv
// Round-to-nearest-even, overflow/underflow detection and result packing for
// the normal (non-special) division path. Purely combinational.
module fdiv_rne
  import fdiv_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic               sign,
  input  logic [EXP_W+1:0]   exp_in,
  input  logic [FRAC_W-1:0]  frac_in,
  input  logic               guard,
  input  logic               sticky,
  output logic [EXP_W+FRAC_W:0] result,
  output logic [4:0]         flags
);

  localparam int W = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W+1:0] EXP_MAX_C = {2'b00, {EXP_W{1'b1}}};

  logic              round_up_s;
  logic [FRAC_W:0]   frac_sum_s;
  logic [EXP_W+1:0]  exp_r_s;
  logic              ovf_s;
  logic              udf_s;

  // Round the fraction, propagate carry into the exponent, then pack or saturate.
  always_comb begin
    round_up_s = guard & (sticky | frac_in[0]);
    frac_sum_s = {1'b0, frac_in} + {{FRAC_W{1'b0}}, round_up_s};
    // A carry out leaves the fraction all zero, i.e. mantissa 1.0 one binade up.
    exp_r_s    = exp_in + {{(EXP_W+1){1'b0}}, frac_sum_s[FRAC_W]};
    ovf_s      = ~exp_r_s[EXP_W+1] & (exp_r_s >= EXP_MAX_C);
    udf_s      = exp_r_s[EXP_W+1] | (exp_r_s == {(EXP_W+2){1'b0}});
    if (ovf_s) begin
      result = W'(fdiv_inf(EXP_W, FRAC_W, sign));
      flags  = 5'b00101;
    end else if (udf_s) begin
      result = W'(fdiv_zero(EXP_W, FRAC_W, sign));
      flags  = 5'b00011;
    end else begin
      result = {sign, exp_r_s[EXP_W-1:0], frac_sum_s[FRAC_W-1:0]};
      flags  = {4'b0000, guard | sticky};
    end
  end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative radix-2 restoring floating-point divider with valid/ready handshake.
// Special operands resolve in one cycle; normal operands take one quotient bit
// per cycle, then a rounding cycle.
module fdiv_iter
  import fdiv_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] dividend,
  input  logic [EXP_W+FRAC_W:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic [4:0]            flags
);

  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int Q     = fdiv_q(FRAC_W);
  localparam int CNT_W = $clog2(Q);
  localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(Q - 1);
  localparam logic [EXP_W+1:0] BIAS_C     = (EXP_W+2)'(fdiv_bias(EXP_W));
  localparam logic [W-1:0]     QNAN_C     = W'(fdiv_qnan(EXP_W, FRAC_W));

  fdiv_state_e        state_q, state_d;
  logic               sign_q, sign_d;
  logic [EXP_W+1:0]   exp_q, exp_d;
  logic [FRAC_W:0]    mb_q, mb_d;
  logic [FRAC_W+1:0]  rem_q, rem_d;
  logic [Q-1:0]       quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [EXP_W-1:0]   ea_s, eb_s;
  logic [FRAC_W-1:0]  fa_s, fb_s;
  logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic               sign_s;
  logic               spec_hit_s;
  logic [W-1:0]       spec_res_s;
  logic [4:0]         spec_flg_s;
  logic [FRAC_W+1:0]  rem_diff_s;
  logic [EXP_W+1:0]   rn_exp_s;
  logic [FRAC_W-1:0]  rn_frac_s;
  logic               rn_guard_s, rn_sticky_s;
  logic [W-1:0]       rne_result_s;
  logic [4:0]         rne_flags_s;

  assign ea_s   = dividend[W-2:FRAC_W];
  assign eb_s   = divisor[W-2:FRAC_W];
  assign fa_s   = dividend[FRAC_W-1:0];
  assign fb_s   = divisor[FRAC_W-1:0];
  assign sign_s = dividend[W-1] ^ divisor[W-1];

  // Classify incoming operands; exponent 0 counts as zero regardless of fraction.
  always_comb begin
    a_zero_s = (ea_s == {EXP_W{1'b0}});
    b_zero_s = (eb_s == {EXP_W{1'b0}});
    a_inf_s  = (ea_s == {EXP_W{1'b1}}) && (fa_s == {FRAC_W{1'b0}});
    b_inf_s  = (eb_s == {EXP_W{1'b1}}) && (fb_s == {FRAC_W{1'b0}});
    a_nan_s  = (ea_s == {EXP_W{1'b1}}) && (fa_s != {FRAC_W{1'b0}});
    b_nan_s  = (eb_s == {EXP_W{1'b1}}) && (fb_s != {FRAC_W{1'b0}});
  end

  // Resolve special operand combinations in priority order.
  always_comb begin
    spec_hit_s = 1'b1;
    spec_res_s = {W{1'b0}};
    spec_flg_s = 5'b00000;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_res_s = QNAN_C;
      spec_flg_s = 5'b10000;
    end else if (b_zero_s && !a_inf_s) begin
      spec_res_s = W'(fdiv_inf(EXP_W, FRAC_W, sign_s));
      spec_flg_s = 5'b01000;
    end else if (a_inf_s) begin
      spec_res_s = W'(fdiv_inf(EXP_W, FRAC_W, sign_s));
    end else if (a_zero_s || b_inf_s) begin
      spec_res_s = W'(fdiv_zero(EXP_W, FRAC_W, sign_s));
    end else begin
      spec_hit_s = 1'b0;
    end
  end

  // Normalise the raw quotient into fraction, guard, sticky and exponent.
  always_comb begin
    if (quo_q[Q-1]) begin
      rn_frac_s   = quo_q[Q-2:2];
      rn_guard_s  = quo_q[1];
      rn_sticky_s = quo_q[0] | (|rem_q);
      rn_exp_s    = exp_q;
    end else begin
      rn_frac_s   = quo_q[Q-3:1];
      rn_guard_s  = quo_q[0];
      rn_sticky_s = |rem_q;
      rn_exp_s    = exp_q - {{(EXP_W+1){1'b0}}, 1'b1};
    end
  end

  fdiv_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_rne (
    .sign    (sign_q),
    .exp_in  (rn_exp_s),
    .frac_in (rn_frac_s),
    .guard   (rn_guard_s),
    .sticky  (rn_sticky_s),
    .result  (rne_result_s),
    .flags   (rne_flags_s)
  );

  // Next-state logic: handshake, one restoring step per DIV cycle, rounding.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    flags_d    = flags_q;
    rem_diff_s = rem_q - {1'b0, mb_q};
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = sign_s;
          // Signed EXP_W+2 bits cannot wrap for any pair of finite exponents.
          exp_d  = {2'b00, ea_s} - {2'b00, eb_s} + BIAS_C;
          mb_d   = {1'b1, fb_s};
          rem_d  = {1'b0, 1'b1, fa_s};
          quo_d  = {Q{1'b0}};
          cnt_d  = {CNT_W{1'b0}};
          if (spec_hit_s) begin
            result_d = spec_res_s;
            flags_d  = spec_flg_s;
            state_d  = S_DONE;
          end else begin
            state_d  = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        // Remainder stays below twice the divisor, so dropping the top bit on shift is safe.
        if (rem_q >= {1'b0, mb_q}) begin
          quo_d = {quo_q[Q-2:0], 1'b1};
          rem_d = rem_diff_s << 1;
        end else begin
          quo_d = {quo_q[Q-2:0], 1'b0};
          rem_d = rem_q << 1;
        end
        if (cnt_q == CNT_LAST_C) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_RND;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = S_DIV;
        end
      end
      S_RND: begin
        result_d = rne_result_s;
        flags_d  = rne_flags_s;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset discarding any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= {(EXP_W+2){1'b0}};
      mb_q        <= {(FRAC_W+1){1'b0}};
      rem_q       <= {(FRAC_W+2){1'b0}};
      quo_q       <= {Q{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      result_q    <= {W{1'b0}};
      flags_q     <= 5'b00000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Scoreboard bench for fdiv_iter at default parameters (binary32).
module tb_fdiv_iter;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  fdiv_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Drive one operation at a negedge; optionally queue its expected outcome.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic push,
                          input logic [31:0] res, input logic [4:0] flg, input int lat);
    exp_t e;
    @(negedge clk);
    check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    if (push) begin
      e.res = res;
      e.flg = flg;
      e.lat = lat[7:0];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Wait (bounded) for out_valid, then pop and compare against the scoreboard.
  task automatic wait_out(input string tag);
    int   cyc;
    exp_t e;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 200);
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_nonempty"}, sb_q.size(), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_res"}, result, e.res);
      check_val({tag, "_flags"}, {27'd0, flags}, {27'd0, e.flg});
      check_val({tag, "_latency"}, cyc, {24'd0, e.lat});
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_rel_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_rel_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  localparam int N_OPS = 17;
  logic [31:0] op_a   [N_OPS] = '{32'h40C00000, 32'h3F800000, 32'hC0000000, 32'h00000000,
                                  32'h7F7FFFFF, 32'h00800000, 32'h41200000, 32'h7F800001,
                                  32'h7F800000, 32'hFF800000, 32'h40000000, 32'h00000001,
                                  32'h3F800000, 32'h7F800000, 32'h3FC00000, 32'h40000000,
                                  32'h3F800000};
  logic [31:0] op_b   [N_OPS] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                                  32'h3F000000, 32'h40000000, 32'hC0A00000, 32'h3F800000,
                                  32'h7F800000, 32'h40000000, 32'hFF800000, 32'h3F800000,
                                  32'h00000001, 32'h00000000, 32'h3F800000, 32'h40400000,
                                  32'h40A00000};
  logic [31:0] op_res [N_OPS] = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h7FC00000,
                                  32'h7F800000, 32'h00000000, 32'hC0000000, 32'h7FC00000,
                                  32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000,
                                  32'h7F800000, 32'h7F800000, 32'h3FC00000, 32'h3F2AAAAB,
                                  32'h3E4CCCCD};
  logic [4:0]  op_flg [N_OPS] = '{5'b00000, 5'b00001, 5'b01000, 5'b10000,
                                  5'b00101, 5'b00011, 5'b00000, 5'b10000,
                                  5'b10000, 5'b00000, 5'b00000, 5'b00000,
                                  5'b01000, 5'b00000, 5'b00000, 5'b00001,
                                  5'b00001};
  int          op_lat [N_OPS] = '{28, 28, 1, 1, 28, 28, 28, 1, 1, 1, 1, 1, 1, 1, 28, 28, 28};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stale;
    // Reset with a coincident in_valid: no operation may be accepted.
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    dividend  = 32'h40C00000;
    divisor   = 32'h40000000;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_flags", {27'd0, flags}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("post_rst_no_accept", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < N_OPS; i++) begin
      start_op(op_a[i], op_b[i], 1'b1, op_res[i], op_flg[i], op_lat[i]);
      wait_out($sformatf("op%0d", i));
      release_out($sformatf("op%0d", i));
    end

    // Back-pressure: result must hold, in_valid must be ignored while in DONE.
    start_op(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 5'b00000, 28);
    wait_out("stall");
    in_valid = 1'b1;
    dividend = 32'h3F800000;
    divisor  = 32'h40400000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val("stall_result", result, 32'h40400000);
      check_val("stall_valid", {31'd0, out_valid}, 32'd1);
      check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    check_val("stall_flags", {27'd0, flags}, 32'd0);
    in_valid = 1'b0;
    release_out("stall");
    stale = 0;
    repeat (35) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_val("stall_no_accept", stale, 32'd0);

    // Reset in the middle of DIV, coincident with in_valid.
    start_op(32'h3F800000, 32'h40400000, 1'b0, 32'd0, 5'b00000, 0);
    repeat (5) @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    dividend = 32'h3F800000;
    divisor  = 32'h40A00000;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check_val("mid_rst_result", result, 32'd0);
    check_val("mid_rst_flags", {27'd0, flags}, 32'd0);
    start_op(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 5'b00000, 28);
    wait_out("after_rst");
    release_out("after_rst");
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_val("no_stale", stale, 32'd0);
    check_val("sb_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
